// File: rtl/mem_bus_arbiter_if.sv
// Two-requester memory bus bundle: requester-side request fields plus the
// shared bus, grant, done and error signals produced by mem_bus_arbiter.
interface mem_bus_arbiter_if;
   logic        req0;
   logic        we0;
   logic        cs0;
   logic        lock0;
   logic [31:0] addr0;
   logic [1:0]  size0;
   logic        req1;
   logic        we1;
   logic        cs1;
   logic        lock1;
   logic [31:0] addr1;
   logic [1:0]  size1;
   logic        grant0;
   logic        grant1;
   logic        done0;
   logic        done1;
   logic        err0;
   logic        err1;
   logic [31:0] mem_address;
   logic [1:0]  mem_size;
   logic        mem_read;
   logic        mem_write_en;
   logic        ram_sel;
   logic        rom_sel;
   logic        peri_sel;

   modport master (
      output req0, we0, cs0, lock0, addr0, size0,
      output req1, we1, cs1, lock1, addr1, size1,
      input  grant0, grant1, done0, done1, err0, err1,
      input  mem_address, mem_size, mem_read, mem_write_en,
      input  ram_sel, rom_sel, peri_sel
   );

   modport slave (
      input  req0, we0, cs0, lock0, addr0, size0,
      input  req1, we1, cs1, lock1, addr1, size1,
      output grant0, grant1, done0, done1, err0, err1,
      output mem_address, mem_size, mem_read, mem_write_en,
      output ram_sel, rom_sel, peri_sel
   );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Two-requester memory bus arbiter with lock chaining and RAM/ROM/GPIO decode.
// Define ARB_ROUND_ROBIN_EN for round-robin contention; default is fixed priority to requester 0.
module mem_bus_arbiter #(
   parameter int unsigned ACCESS_CYCLES    = 1,
   parameter int unsigned MAX_LOCK         = 4,
   parameter logic [31:0] GPIO_DIR_ADDRESS = 32'd254,
   parameter logic [31:0] GPIO_RW_ADDRESS  = 32'd255
) (
   input logic              clock,
   input logic              reset,
   mem_bus_arbiter_if.slave bus
);
   typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

   localparam int CNT_W   = 4;
   localparam int CHAIN_W = $clog2(MAX_LOCK + 1);

   state_t             state_r, state_s;
   logic               owner_r, owner_s;
   logic [CNT_W-1:0]   cnt_r, cnt_s;
   logic [CHAIN_W-1:0] chain_r, chain_s;
   logic               any_req_s, winner_s, busy_s, last_s;
   logic               own_req_s, own_lock_s, own_we_s, own_cs_s;
   logic [31:0]        own_addr_s;
   logic [1:0]         own_size_s;
   logic               peri_s, ram_s, rom_s;

   assign any_req_s = bus.req0 | bus.req1;
   assign busy_s    = (state_r == BUSY);
   assign last_s    = busy_s && (cnt_r == 4'd1);

`ifdef ARB_ROUND_ROBIN_EN
   logic prio_r;

   // Contention winner: the requester holding the priority pointer.
   always_comb begin
      if (bus.req0 && bus.req1) begin
         winner_s = prio_r;
      end else begin
         winner_s = ~bus.req0;
      end
   end

   // Priority pointer moves to the other requester on every fresh grant.
   always_ff @(posedge clock) begin
      if (reset) begin
         prio_r <= 1'b0;
      end else if (!busy_s && any_req_s) begin
         prio_r <= ~winner_s;
      end else begin
         prio_r <= prio_r;
      end
   end
`else
   // Fixed priority: requester 0 wins whenever it asks.
   always_comb begin
      if (bus.req0) begin
         winner_s = 1'b0;
      end else begin
         winner_s = 1'b1;
      end
   end
`endif

   // Route the owning requester's fields toward the shared bus.
   always_comb begin
      if (owner_r) begin
         own_req_s  = bus.req1;
         own_lock_s = bus.lock1;
         own_we_s   = bus.we1;
         own_cs_s   = bus.cs1;
         own_addr_s = bus.addr1;
         own_size_s = bus.size1;
      end else begin
         own_req_s  = bus.req0;
         own_lock_s = bus.lock0;
         own_we_s   = bus.we0;
         own_cs_s   = bus.cs0;
         own_addr_s = bus.addr0;
         own_size_s = bus.size0;
      end
   end

   // Target decode: the two GPIO registers override the RAM/ROM chip select.
   always_comb begin
      peri_s = 1'b0;
      ram_s  = 1'b0;
      rom_s  = 1'b0;
      if (busy_s) begin
         if ((own_addr_s == GPIO_DIR_ADDRESS) || (own_addr_s == GPIO_RW_ADDRESS)) begin
            peri_s = 1'b1;
         end else begin
            ram_s = own_cs_s;
            rom_s = ~own_cs_s;
         end
      end else begin
         peri_s = 1'b0;
      end
   end

   assign bus.grant0       = busy_s & ~owner_r;
   assign bus.grant1       = busy_s & owner_r;
   assign bus.done0        = last_s & ~owner_r;
   assign bus.done1        = last_s & owner_r;
   assign bus.err0         = last_s & ~owner_r & own_we_s & rom_s;
   assign bus.err1         = last_s & owner_r & own_we_s & rom_s;
   assign bus.mem_address  = busy_s ? own_addr_s : 32'd0;
   assign bus.mem_size     = busy_s ? own_size_s : 2'd0;
   assign bus.mem_read     = busy_s & ~own_we_s;
   assign bus.mem_write_en = busy_s & own_we_s & ~rom_s;
   assign bus.ram_sel      = ram_s;
   assign bus.rom_sel      = rom_s;
   assign bus.peri_sel     = peri_s;

   // Next state: grant from IDLE, count down the access, chain or release at the end.
   always_comb begin
      state_s = state_r;
      owner_s = owner_r;
      cnt_s   = cnt_r;
      chain_s = chain_r;
      case (state_r)
         IDLE: begin
            if (any_req_s) begin
               state_s = BUSY;
               owner_s = winner_s;
               cnt_s   = CNT_W'(ACCESS_CYCLES);
               chain_s = CHAIN_W'(1);
            end else begin
               chain_s = {CHAIN_W{1'b0}};
            end
         end
         BUSY: begin
            if (cnt_r == 4'd1) begin
               // chain_r counts accesses already made in this tenure
               if (own_lock_s && own_req_s && (chain_r < CHAIN_W'(MAX_LOCK))) begin
                  cnt_s   = CNT_W'(ACCESS_CYCLES);
                  chain_s = chain_r + CHAIN_W'(1);
               end else begin
                  state_s = IDLE;
                  cnt_s   = 4'd0;
                  chain_s = {CHAIN_W{1'b0}};
               end
            end else begin
               cnt_s = cnt_r - 4'd1;
            end
         end
         default: begin
            state_s = IDLE;
            cnt_s   = 4'd0;
            chain_s = {CHAIN_W{1'b0}};
         end
      endcase
   end

   // State register; reset aborts any access in flight.
   always_ff @(posedge clock) begin
      if (reset) begin
         state_r <= IDLE;
         owner_r <= 1'b0;
         cnt_r   <= 4'd0;
         chain_r <= {CHAIN_W{1'b0}};
      end else begin
         state_r <= state_s;
         owner_r <= owner_s;
         cnt_r   <= cnt_s;
         chain_r <= chain_s;
      end
   end
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench: two arbiters (1-cycle and 3-cycle accesses) share one stimulus
// stream and are compared every cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;
   localparam int AC_A = 1;
   localparam int AC_B = 3;
   localparam int ML   = 4;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        req[2];
   logic        we[2];
   logic        cs[2];
   logic        lock[2];
   logic [31:0] addr[2];
   logic [1:0]  size[2];

   int errors = 0;
   int checks = 0;

   // Reference model: owner (-1 when idle), cycles left in the access, accesses in tenure
   int m_owner[2];
   int m_left[2];
   int m_tenure[2];
   int m_prio[2];

   mem_bus_arbiter_if bus_a();
   mem_bus_arbiter_if bus_b();

   mem_bus_arbiter #(.ACCESS_CYCLES(AC_A), .MAX_LOCK(ML)) dut_a (.clock(clock), .reset(reset), .bus(bus_a));
   mem_bus_arbiter #(.ACCESS_CYCLES(AC_B), .MAX_LOCK(ML)) dut_b (.clock(clock), .reset(reset), .bus(bus_b));

   assign bus_a.req0 = req[0];   assign bus_a.req1 = req[1];
   assign bus_a.we0 = we[0];     assign bus_a.we1 = we[1];
   assign bus_a.cs0 = cs[0];     assign bus_a.cs1 = cs[1];
   assign bus_a.lock0 = lock[0]; assign bus_a.lock1 = lock[1];
   assign bus_a.addr0 = addr[0]; assign bus_a.addr1 = addr[1];
   assign bus_a.size0 = size[0]; assign bus_a.size1 = size[1];
   assign bus_b.req0 = req[0];   assign bus_b.req1 = req[1];
   assign bus_b.we0 = we[0];     assign bus_b.we1 = we[1];
   assign bus_b.cs0 = cs[0];     assign bus_b.cs1 = cs[1];
   assign bus_b.lock0 = lock[0]; assign bus_b.lock1 = lock[1];
   assign bus_b.addr0 = addr[0]; assign bus_b.addr1 = addr[1];
   assign bus_b.size0 = size[0]; assign bus_b.size1 = size[1];

   logic [44:0] obs_a, obs_b;
   assign obs_a = {bus_a.grant0, bus_a.grant1, bus_a.done0, bus_a.done1, bus_a.err0, bus_a.err1,
                   bus_a.mem_read, bus_a.mem_write_en, bus_a.ram_sel, bus_a.rom_sel, bus_a.peri_sel,
                   bus_a.mem_size, bus_a.mem_address};
   assign obs_b = {bus_b.grant0, bus_b.grant1, bus_b.done0, bus_b.done1, bus_b.err0, bus_b.err1,
                   bus_b.mem_read, bus_b.mem_write_en, bus_b.ram_sel, bus_b.rom_sel, bus_b.peri_sel,
                   bus_b.mem_size, bus_b.mem_address};

   always #5 clock = ~clock;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic int access_len(input int k);
      return (k == 0) ? AC_A : AC_B;
   endfunction

   // Advance the model by one bus cycle using the inputs present at the edge.
   task automatic model_update();
      for (int k = 0; k < 2; k++) begin
         if (reset) begin
            m_owner[k] = -1; m_left[k] = 0; m_tenure[k] = 0; m_prio[k] = 0;
         end else if (m_owner[k] < 0) begin
            if (req[0] || req[1]) begin
               int w;
               if (req[0] && req[1]) begin
`ifdef ARB_ROUND_ROBIN_EN
                  w = m_prio[k];
`else
                  w = 0;
`endif
               end else begin
                  w = req[0] ? 0 : 1;
               end
               m_owner[k]  = w;
               m_left[k]   = access_len(k);
               m_tenure[k] = 1;
               m_prio[k]   = 1 - w;
            end
         end else if (m_left[k] == 1) begin
            int o = m_owner[k];
            if (lock[o] && req[o] && m_tenure[k] < ML) begin
               m_left[k] = access_len(k);
               m_tenure[k]++;
            end else begin
               m_owner[k] = -1; m_left[k] = 0; m_tenure[k] = 0;
            end
         end else begin
            m_left[k]--;
         end
      end
   endtask

   function automatic logic [44:0] model_out(input int k);
      int   o;
      logic peri, ram, rom, dn, er;
      o = m_owner[k];
      if (o < 0) return 45'd0;
      peri = (addr[o] == 32'd254) || (addr[o] == 32'd255);
      ram  = !peri && cs[o];
      rom  = !peri && !cs[o];
      dn   = (m_left[k] == 1);
      er   = dn && we[o] && rom;
      return {o == 0, o == 1, dn && o == 0, dn && o == 1, er && o == 0, er && o == 1,
              !we[o], we[o] && !rom, ram, rom, peri, size[o], addr[o]};
   endfunction

   // One clock: update the model at the edge, then compare both DUTs just after it.
   task automatic step();
      logic [44:0] exp;
      @(posedge clock);
      model_update();
      #1;
      exp = model_out(0);
      check_eq("a.ctl", obs_a[44:34], exp[44:34]);
      check_eq("a.bus", obs_a[33:0], exp[33:0]);
      exp = model_out(1);
      check_eq("b.ctl", obs_b[44:34], exp[44:34]);
      check_eq("b.bus", obs_b[33:0], exp[33:0]);
   endtask

   task automatic clear_inputs();
      for (int k = 0; k < 2; k++) begin
         req[k] = 1'b0; we[k] = 1'b0; cs[k] = 1'b0; lock[k] = 1'b0;
         addr[k] = 32'd0; size[k] = 2'd0;
      end
   endtask

   task automatic do_reset();
      clear_inputs();
      reset = 1'b1;
      step();
      step();
      reset = 1'b0;
   endtask

   initial begin
      clear_inputs();
      do_reset();
      check_eq("reset.a", obs_a, 45'd0);
      check_eq("reset.b", obs_b, 45'd0);

      // Single 1-cycle RAM read from requester 0
      req[0] = 1'b1; cs[0] = 1'b1; addr[0] = 32'h10; size[0] = 2'd2;
      step();
      check_eq("r036.grant0", bus_a.grant0, 1'b1);
      check_eq("r036.ram_sel", bus_a.ram_sel, 1'b1);
      check_eq("r036.mem_read", bus_a.mem_read, 1'b1);
      check_eq("r036.done0", bus_a.done0, 1'b1);
      req[0] = 1'b0;
      repeat (4) step();

      // Contention without lock: fresh arbitration after every access
      do_reset();
      req[0] = 1'b1; req[1] = 1'b1; cs[0] = 1'b1; cs[1] = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         if (i % 2 == 0) begin
`ifdef ARB_ROUND_ROBIN_EN
            check_eq("r037.owner", {bus_a.grant1, bus_a.grant0}, ((i / 2) % 2 == 0) ? 2'b01 : 2'b10);
`else
            check_eq("r037.owner", {bus_a.grant1, bus_a.grant0}, 2'b01);
`endif
         end else begin
            check_eq("r037.idle", {bus_a.grant1, bus_a.grant0}, 2'b00);
         end
      end

      // GPIO decode for requester 1 writes
      do_reset();
      req[1] = 1'b1; we[1] = 1'b1; cs[1] = 1'b1; addr[1] = 32'd255;
      step();
      check_eq("r038.sel255", {bus_a.peri_sel, bus_a.ram_sel, bus_a.rom_sel, bus_a.mem_write_en}, 4'b1001);
      addr[1] = 32'd254;
      step();
      step();
      check_eq("r038.sel254", {bus_a.grant1, bus_a.peri_sel, bus_a.ram_sel, bus_a.rom_sel}, 4'b1100);
      req[1] = 1'b0;
      repeat (4) step();

      // ROM write is suppressed and flagged
      do_reset();
      req[0] = 1'b1; we[0] = 1'b1; cs[0] = 1'b0; addr[0] = 32'h40;
      step();
      check_eq("r039.rom", {bus_a.rom_sel, bus_a.mem_write_en}, 2'b10);
      check_eq("r039.done_err", {bus_a.done0, bus_a.err0}, 2'b11);
      req[0] = 1'b0;
      repeat (4) step();

      // Lock chain capped at ML accesses, then the other requester gets the bus
      do_reset();
      req[0] = 1'b1; lock[0] = 1'b1; cs[0] = 1'b1; req[1] = 1'b1; cs[1] = 1'b1;
      for (int i = 0; i < ML; i++) begin
         step();
         check_eq("r040.chain", {bus_a.grant0, bus_a.done0}, 2'b11);
      end
      req[0] = 1'b0; lock[0] = 1'b0;
      step();
      check_eq("r040.idle", {bus_a.grant0, bus_a.grant1}, 2'b00);
      step();
      check_eq("r040.grant1", bus_a.grant1, 1'b1);
      req[1] = 1'b0;
      repeat (4) step();

      // Reset in the second cycle of a 3-cycle access
      do_reset();
      req[0] = 1'b1; cs[0] = 1'b1; addr[0] = 32'h10;
      step();
      check_eq("r041.busy1", bus_b.grant0, 1'b1);
      step();
      check_eq("r041.busy2", {bus_b.grant0, bus_b.done0}, 2'b10);
      reset = 1'b1;
      step();
      check_eq("r041.abort", obs_b, 45'd0);
      reset = 1'b0;
      clear_inputs();
      step();

      // Randomized traffic with occasional resets
      for (int n = 0; n < 800; n++) begin
         reset = ($urandom_range(0, 99) == 0);
         for (int k = 0; k < 2; k++) begin
            int pick;
            req[k]  = ($urandom_range(0, 3) != 0);
            lock[k] = ($urandom_range(0, 3) != 0);
            we[k]   = 1'($urandom_range(0, 1));
            cs[k]   = 1'($urandom_range(0, 1));
            size[k] = 2'($urandom_range(0, 3));
            pick    = $urandom_range(0, 3);
            case (pick)
               0: addr[k] = 32'd254;
               1: addr[k] = 32'd255;
               2: addr[k] = 32'h40;
               default: addr[k] = $urandom;
            endcase
         end
         step();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mem_bus_arbiter.md
MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

Interface
REQ-001 Parameter ACCESS_CYCLES, 1, bus cycles per granted access (1..15).
REQ-002 Parameter MAX_LOCK, 4, maximum back-to-back accesses one requester may chain under lock.
REQ-003 Parameter GPIO_DIR_ADDRESS, 32'd254, GPIO direction register address.
REQ-004 Parameter GPIO_RW_ADDRESS, 32'd255, GPIO data register address.
REQ-005 clock  in  1  single clock; all state updates on rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 reqN  in  1  (N=0 CPU datapath, N=1 DMA/debug) access request; held until doneN.
REQ-008 weN  in  1  requester N write (1) / read (0).
REQ-009 csN  in  1  requester N memory select: 1 RAM, 0 ROM.
REQ-010 lockN  in  1  requester N wants to keep the bus after this access.
REQ-011 addrN  in  32  requester N byte address.
REQ-012 sizeN  in  2  requester N access size code, passed through unchanged.
REQ-013 grantN  out  1  requester N owns the bus.
REQ-014 doneN  out  1  one-cycle pulse: requester N access complete.
REQ-015 errN  out  1  one-cycle pulse with doneN: requester N attempted a ROM write.
REQ-016 mem_address  out  32  shared bus address.
REQ-017 mem_size  out  2  shared bus size code.
REQ-018 mem_read, mem_write_en  out  1 each  shared bus read/write strobes.
REQ-019 ram_sel, rom_sel, peri_sel  out  1 each  one-hot target selects.

Function
REQ-020 States SHALL be IDLE and BUSY; exactly one grantN SHALL be high in BUSY, none in IDLE.
REQ-021 In IDLE with any req high at edge T, the arbiter SHALL enter BUSY at T+1 with the winner's grant high and the cycle counter loaded with ACCESS_CYCLES.
REQ-022 With one requester active it SHALL win; with both active the winner SHALL be chosen by the priority rule (REQ-035).
REQ-023 In BUSY, mem_address/mem_size/mem_read/mem_write_en/selects SHALL be driven combinationally from the granted requester's inputs; in IDLE all SHALL be 0.
REQ-024 Decode: peri_sel=1 when address equals GPIO_DIR_ADDRESS or GPIO_RW_ADDRESS; else ram_sel=cs, rom_sel=~cs; selects always one-hot in BUSY.
REQ-025 mem_read SHALL equal ~we; mem_write_en SHALL equal we except forced 0 when rom_sel=1.
REQ-026 doneN SHALL pulse in the last BUSY cycle of the access (counter==1); errN SHALL pulse in the same cycle if we=1 and rom_sel=1.
REQ-027 Latency: request-to-done SHALL be exactly ACCESS_CYCLES+1 cycles from IDLE.
REQ-028 At done, if the owner's lock and req are both high and its chain count < MAX_LOCK, the arbiter SHALL stay BUSY with the same grant, reload the counter and increment the chain count.
REQ-029 Otherwise at done it SHALL return to IDLE for one cycle and clear the chain count; re-arbitration occurs from IDLE.
REQ-030 After MAX_LOCK chained accesses the lock SHALL be ignored and the bus released, even if the other requester is idle.
REQ-031 Dropping reqN mid-access SHALL NOT abort the access; it completes and releases.
REQ-032 Requester inputs changing while granted SHALL propagate to the bus (requester must hold stable; not checked).

Reset
REQ-033 reset SHALL force IDLE, all grant/done/err and bus outputs 0, chain count 0, counter 0, priority pointer to requester 0.
REQ-034 reset asserted during BUSY SHALL abort the access with no doneN pulse.

Configuration
REQ-035 Macro ARB_ROUND_ROBIN_EN defined: on contention the requester not granted last SHALL win (pointer updates at each grant); undefined: requester 0 SHALL always win on contention, no pointer state.

Verification
REQ-036 ACCESS_CYCLES=1, req0 read addr 0x10 cs=1 -> grant0 next cycle, ram_sel=1, mem_read=1, done0 2 cycles after req.
REQ-037 Both req high, ARB_ROUND_ROBIN_EN defined, held for 4 accesses -> grants alternate 0,1,0,1 with one IDLE cycle between; undefined -> all four to requester 0.
REQ-038 req1 write addr 255 -> peri_sel=1, mem_write_en=1, ram_sel=rom_sel=0; addr 254 -> peri_sel=1.
REQ-039 req0 write cs=0 addr 0x40 -> rom_sel=1, mem_write_en=0, done0 and err0 pulse together.
REQ-040 MAX_LOCK=4, req0+lock0 held, req1 high -> four consecutive done0 without IDLE, then IDLE, then grant1.
REQ-041 ACCESS_CYCLES=3, reset asserted in second BUSY cycle -> next cycle all outputs 0, no done0.
